// File: rtl/amo_mem_responder.sv
// amo_mem_responder: word-addressed data memory answering single-word load,
// store and atomic-swap requests after a fixed latency.
// Each request is latched on acceptance in IDLE. mem_resp pulses for one cycle
// exactly LATENCY cycles later. mem_rdata carries the pre-write word during that pulse.
// The masked write commits on the edge that ends the response cycle.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   mem_addr               byte address; only the word-index bits are used
//   mem_read, mem_write    request qualifiers, held by the requester until mem_resp
//   mem_wmask, mem_wdata   byte enables and data for the write half of a transaction
//   mem_rdata, mem_resp    old word and one-cycle completion pulse
module amo_mem_responder #(
  parameter int ADDR_WORDS_LOG2 = 8,
  parameter int LATENCY         = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_wmask,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp
);

  localparam int WORDS = 1 << ADDR_WORDS_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                     state, state_nxt;
  logic [ADDR_WORDS_LOG2-1:0] idx_q;
  logic [3:0]                 wmask_q;
  logic [31:0]                wdata_q;
  logic                       rd_q;
  logic                       wr_q;
  logic [3:0]                 cnt_q;

  logic [31:0] mem [WORDS];

  // Byte-offset bits and address bits above the array size are don't-care;
  // the array simply aliases across the address space.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:ADDR_WORDS_LOG2+2], mem_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (mem_read || mem_write) state_nxt = (LATENCY == 1) ? RESP : WAIT;
      // cnt_q was loaded with LATENCY-1 at acceptance, so leaving WAIT when it
      // reads 1 puts RESP exactly LATENCY cycles after the accepting cycle.
      WAIT: if (cnt_q <= 4'd1) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latches: captured only in IDLE, so inputs are ignored in WAIT/RESP
  // and any later change of address/data/mask cannot disturb the transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      wmask_q <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mem_read || mem_write) begin
            idx_q   <= mem_addr[ADDR_WORDS_LOG2+1:2];
            wmask_q <= mem_wmask;
            wdata_q <= mem_wdata;
            rd_q    <= mem_read;
            wr_q    <= mem_write;
            cnt_q   <= 4'(LATENCY - 1);
          end
        end
        WAIT:    cnt_q <= cnt_q - 4'd1;
        default: ;
      endcase
    end
  end

  // Array is not reset. The write lands only on the edge that closes RESP.
  // A reset mid-transaction forces IDLE and drops the pending write.
  always_ff @(posedge clk) begin
    if (!rst && state == RESP && wr_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  // Outputs depend only on registered state and the latched index.
  // The read sees the array before this transaction's write commits.
  assign mem_resp  = (state == RESP) && (rd_q || wr_q);
  assign mem_rdata = mem_resp ? mem[idx_q] : 32'd0;

endmodule
